nrzi_rx_decoder: RTL and testbench

Serial line receiver that reverses the inverting NRZI line code driven by our transmit side. The line carries a transition for a logic 0 and no transition for a logic 1. The block decodes the level stream one bit per bit strobe and hunts for a sync byte. After sync it removes stuffed bits and deserialises payload bits LSB-first into bytes, presenting each byte with a one-cycle valid pulse. It sits between the pad-side bit-timing logic, which supplies bit_en, and the byte-level packet logic.

---
 rtl/nrzi_rx_decoder.sv | 119 +++++++++++
 tb/tb_nrzi_rx_decoder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrzi_rx_decoder.sv
// Inverting-NRZI line receiver: decodes levels, hunts for the sync byte, then
// removes stuffed zeros and emits payload bytes LSB-first with a valid pulse.
module nrzi_rx_decoder #(
    parameter logic [7:0] SYNC_PATTERN = 8'h80,
    parameter int         MAX_ONES     = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_en,
    input  logic       rx_en,
    input  logic       din,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       sync_det,
    output logic       stuff_err,
    output logic       busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HUNT = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0] state;
    logic       prev_lvl;
    logic [7:0] hunt_sr;
    logic [7:0] data_sr;
    logic [2:0] bit_cnt;
    logic [2:0] ones_cnt;

    logic       dbit;
    logic [7:0] hunt_next;
    logic [7:0] data_next;
    logic       stuff_slot;

    // No level change on the line means a decoded 1.
    assign dbit       = ~(din ^ prev_lvl);
    assign hunt_next  = {dbit, hunt_sr[7:1]};
    assign data_next  = {dbit, data_sr[7:1]};
    assign stuff_slot = (ones_cnt == 3'(MAX_ONES));
    assign busy       = (state == DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev_lvl   <= 1'b1;
            hunt_sr    <= 8'h00;
            data_sr    <= 8'h00;
            bit_cnt    <= 3'd0;
            ones_cnt   <= 3'd0;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            sync_det   <= 1'b0;
            stuff_err  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sync_det   <= 1'b0;
            stuff_err  <= 1'b0;

            // The decoder keeps tracking the line even outside a packet window.
            if (bit_en) begin
                prev_lvl <= din;
            end

            if (!rx_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= HUNT;
                        hunt_sr <= 8'h00;
                    end
                    HUNT: begin
                        if (bit_en) begin
                            hunt_sr <= hunt_next;
                            if (hunt_next == SYNC_PATTERN) begin
                                state    <= DATA;
                                sync_det <= 1'b1;
                                bit_cnt  <= 3'd0;
                                ones_cnt <= 3'd0;
                                data_sr  <= 8'h00;
                            end
                        end
                    end
                    DATA: begin
                        if (bit_en) begin
                            if (stuff_slot) begin
                                // Stuffed bit is never shifted in; a 1 here breaks the framing.
                                if (dbit) begin
                                    stuff_err <= 1'b1;
                                    state     <= ERR;
                                end else begin
                                    ones_cnt <= 3'd0;
                                end
                            end else begin
                                data_sr  <= data_next;
                                ones_cnt <= dbit ? ones_cnt + 3'd1 : 3'd0;
                                if (bit_cnt == 3'd7) begin
                                    dout       <= data_next;
                                    dout_valid <= 1'b1;
                                    bit_cnt    <= 3'd0;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                        end
                    end
                    ERR: begin
                        state <= ERR;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Bench for nrzi_rx_decoder: directed scenarios plus randomized packets, checked
// against a bit-stream reference model and a byte scoreboard.
module tb_nrzi_rx_decoder;

    localparam logic [7:0] SYNC     = 8'h80;
    localparam int         MAX_ONES = 6;
    localparam int M_IDLE = 0;
    localparam int M_HUNT = 1;
    localparam int M_DATA = 2;
    localparam int M_ERR  = 3;

    logic       clk;
    logic       rst_n;
    logic       bit_en;
    logic       rx_en;
    logic       din;
    logic [7:0] dout;
    logic       dout_valid;
    logic       sync_det;
    logic       stuff_err;
    logic       busy;

    nrzi_rx_decoder #(.SYNC_PATTERN(SYNC), .MAX_ONES(MAX_ONES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .rx_en     (rx_en),
        .din       (din),
        .dout      (dout),
        .dout_valid(dout_valid),
        .sync_det  (sync_det),
        .stuff_err (stuff_err),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_mode;
    logic       m_prev;
    bit         win[$];
    bit         pay[$];
    int         m_run;
    logic [7:0] m_dout;
    logic [7:0] exp_q[$];
    logic       exp_sync, exp_valid, exp_stuff;
    logic       line_lvl;
    int         tx_run;
    logic       obs_sync, obs_valid, obs_stuff;

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_prev   = 1'b1;
        line_lvl = 1'b1;
        m_run    = 0;
        m_dout   = 8'h00;
        pay.delete();
        win.delete();
        exp_q.delete();
    endtask

    task automatic model_step(input logic lvl);
        bit         d;
        logic [7:0] val;
        d         = (lvl == m_prev);
        m_prev    = lvl;
        exp_sync  = 1'b0;
        exp_valid = 1'b0;
        exp_stuff = 1'b0;
        if (rx_en) begin
            if (m_mode == M_HUNT) begin
                win.push_back(d);
                void'(win.pop_front());
                for (int i = 0; i < 8; i++) val[i] = win[i];
                if (val == SYNC) begin
                    m_mode   = M_DATA;
                    exp_sync = 1'b1;
                    m_run    = 0;
                    pay.delete();
                end
            end else if (m_mode == M_DATA) begin
                if (m_run == MAX_ONES) begin
                    if (d) begin
                        exp_stuff = 1'b1;
                        m_mode    = M_ERR;
                    end else begin
                        m_run = 0;
                    end
                end else begin
                    pay.push_back(d);
                    m_run = d ? m_run + 1 : 0;
                    if (pay.size() == 8) begin
                        for (int i = 0; i < 8; i++) val[i] = pay[i];
                        pay.delete();
                        m_dout    = val;
                        exp_valid = 1'b1;
                        exp_q.push_back(val);
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check("gap_pulses", {sync_det, dout_valid, stuff_err}, 3'b000);
            check("gap_busy", busy, m_mode == M_DATA);
        end
    endtask

    task automatic drive_lvl(input logic lvl);
        bit_en   = 1'b1;
        din      = lvl;
        line_lvl = lvl;
        model_step(lvl);
        @(posedge clk); #1;
        bit_en    = 1'b0;
        obs_sync  = sync_det;
        obs_valid = dout_valid;
        obs_stuff = stuff_err;
        if (dout_valid) n_valid++;
        if (sync_det || dout_valid || stuff_err) n_pulses++;
        check("sync_det", sync_det, exp_sync);
        check("dout_valid", dout_valid, exp_valid);
        check("stuff_err", stuff_err, exp_stuff);
        check("busy", busy, m_mode == M_DATA);
        if (exp_valid && exp_q.size() > 0) check("dout_sb", dout, exp_q.pop_front());
        check("dout_hold", dout, m_dout);
        idle_cycles($urandom_range(0, 2));
    endtask

    task automatic send_dbit(input bit b);
        drive_lvl(b ? line_lvl : ~line_lvl);
    endtask

    task automatic send_sync();
        repeat (7) send_dbit(1'b0);
        send_dbit(1'b1);
        tx_run = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int corrupt_pct);
        for (int i = 0; i < 8; i++) begin
            send_dbit(b[i]);
            tx_run = b[i] ? tx_run + 1 : 0;
            if (tx_run == MAX_ONES) begin
                send_dbit($urandom_range(0, 99) < corrupt_pct);
                tx_run = 0;
            end
        end
    endtask

    task automatic set_rx(input logic v);
        rx_en = v;
        @(posedge clk); #1;
        if (!v) begin
            m_mode = M_IDLE;
            pay.delete();
        end else if (m_mode == M_IDLE) begin
            m_mode = M_HUNT;
            win.delete();
            repeat (8) win.push_back(1'b0);
        end
        check("rx_busy", busy, m_mode == M_DATA);
        check("rx_pulses", {sync_det, dout_valid, stuff_err}, 3'b000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic lv_sync[8];
        logic lv_a5[8];
        int   v0;
        int   p0;
        lv_sync = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        lv_a5   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rst_n  = 1'b0;
        bit_en = 1'b0;
        rx_en  = 1'b0;
        din    = 1'b1;
        tx_run = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 8'h00);
        check("rst_pulses", {sync_det, dout_valid, stuff_err}, 3'b000);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Sync detect from raw line levels
        set_rx(1'b1);
        foreach (lv_sync[i]) drive_lvl(lv_sync[i]);
        check("tp_sync_pulse", obs_sync, 1'b1);
        check("tp_sync_busy", busy, 1'b1);

        // Single byte 0xA5
        v0 = n_valid;
        foreach (lv_a5[i]) drive_lvl(lv_a5[i]);
        check("tp_a5_valid", obs_valid, 1'b1);
        check("tp_a5_dout", dout, 8'hA5);
        check("tp_a5_count", n_valid - v0, 1);

        // Destuffing: six 1s, stuffed 0, two more 1s
        set_rx(1'b0);
        set_rx(1'b1);
        send_sync();
        v0 = n_valid;
        repeat (6) send_dbit(1'b1);
        send_dbit(1'b0);
        check("tp_stuff_slot_valid", obs_valid, 1'b0);
        check("tp_stuff_slot_busy", busy, 1'b1);
        send_dbit(1'b1);
        send_dbit(1'b1);
        check("tp_ff_valid", obs_valid, 1'b1);
        check("tp_ff_dout", dout, 8'hFF);
        check("tp_ff_count", n_valid - v0, 1);

        // Stuff error: seven 1s in a row
        set_rx(1'b0);
        set_rx(1'b1);
        send_sync();
        v0 = n_valid;
        repeat (7) send_dbit(1'b1);
        check("tp_err_pulse", obs_stuff, 1'b1);
        check("tp_err_busy", busy, 1'b0);
        check("tp_err_novalid", n_valid - v0, 0);
        send_dbit(1'b1);
        check("tp_err_stays", busy, 1'b0);
        set_rx(1'b0);
        set_rx(1'b1);
        send_sync();
        check("tp_rehunt_sync", obs_sync, 1'b1);

        // Abort after four payload bits
        v0 = n_valid;
        send_dbit(1'b1);
        send_dbit(1'b0);
        send_dbit(1'b1);
        send_dbit(1'b1);
        set_rx(1'b0);
        check("tp_abort_busy", busy, 1'b0);
        check("tp_abort_dout", dout, 8'hFF);
        check("tp_abort_novalid", n_valid - v0, 0);
        set_rx(1'b1);
        send_sync();
        send_byte(8'h3C, 0);
        check("tp_3c_valid", obs_valid, 1'b1);
        check("tp_3c_dout", dout, 8'h3C);

        // Asynchronous reset between clock edges, mid-byte
        send_dbit(1'b1);
        send_dbit(1'b0);
        send_dbit(1'b1);
        #3;
        rst_n = 1'b0;
        rx_en = 1'b0;
        din   = 1'b1;
        #1;
        check("ar_dout", dout, 8'h00);
        check("ar_busy", busy, 1'b0);
        check("ar_pulses", {sync_det, dout_valid, stuff_err}, 3'b000);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        p0 = n_pulses;
        repeat (6) drive_lvl(1'($urandom_range(0, 1)));
        check("ar_no_pulses", n_pulses - p0, 0);

        // Randomized packets with occasional corrupted stuff bits and aborts
        for (int pkt = 0; pkt < 40; pkt++) begin
            set_rx(1'b1);
            repeat ($urandom_range(0, 3)) send_dbit(1'($urandom_range(0, 1)));
            send_sync();
            repeat ($urandom_range(1, 4)) begin
                send_byte(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), 15);
            end
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 7)) send_dbit(1'($urandom_range(0, 1)));
            end
            set_rx(1'b0);
            repeat ($urandom_range(0, 2)) drive_lvl(1'($urandom_range(0, 1)));
        end

        check("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so a stalled run still ends with a report.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
